// File: rtl/seven_seg_pkg.sv
// Shared constants for the eight-digit seven-segment scan controller: digit count,
// active-low hex glyph table, reset display value and the register-set layout (SEG_BLINK_EN adds a mask).
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;

    localparam logic [31:0] RESET_NUM = 32'hAA5555AA;

    // Entry n is the active-low {g,f,e,d,c,b,a} glyph for hex value n; entry 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG_N = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef struct packed {
        logic [31:0] num;
        logic [7:0]  point;
        logic [7:0]  blank;
`ifdef SEG_BLINK_EN
        logic [7:0]  mask;
`endif
    } disp_set_t;

    function automatic disp_set_t reset_set();
        disp_set_t r;
        r     = '0;
        r.num = RESET_NUM;
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex2seg.sv
// Combinational hex nibble to active-low seven-segment pattern, dp carried as the MSB.
module hex2seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_n_o
);

    assign seg_n_o = {~dp_i, HEX_SEG_N[nibble_i]};

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment driver with a shadow register set committed only at
// frame boundaries so a frame never mixes old and new digits. Optional blinking under SEG_BLINK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] disp_num,
    input  logic [7:0]  point,
    input  logic [7:0]  blank,
`ifdef SEG_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic        pending,
    output logic        frame_tick,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT
);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || BLINK_FRAMES < 1 || BLINK_FRAMES > 65535) begin : g_bad_param
        $error("seven_seg_scan_ctrl: SCAN_DIV or BLINK_FRAMES out of range");
    end

    localparam logic [15:0]        PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    logic [15:0]        presc_q, presc_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               presc_tc;
    logic               pending_q, pending_d;
    disp_set_t          active_q, active_d;
    disp_set_t          shadow_q, shadow_d;
    disp_set_t          load_set;
    logic [7:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         cur_nibble;
    logic               cur_dp;
    logic               cur_dark;
    logic [7:0]         glyph_n;

    always_comb begin
        presc_tc   = (presc_q == PRESC_LAST);
        frame_tick = presc_tc && (digit_q == LAST_DIGIT);
        presc_d    = presc_tc ? 16'd0 : presc_q + 16'd1;
        digit_d    = presc_tc ? digit_q + 3'd1 : digit_q;
    end

    always_comb begin
        load_set       = '0;
        load_set.num   = disp_num;
        load_set.point = point;
        load_set.blank = blank;
`ifdef SEG_BLINK_EN
        load_set.mask  = blink_mask;
`endif
    end

    // A load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = load_set;
            if (frame_tick) begin
                active_d  = load_set;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (frame_tick && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

`ifdef SEG_BLINK_EN
    localparam logic [15:0] FRAME_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        blink_off_q, blink_off_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_off_d = blink_off_q;
        if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = 16'd0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            blink_off_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign cur_dark = active_q.blank[digit_q] | (blink_off_q & active_q.mask[digit_q]);
`else
    assign cur_dark = active_q.blank[digit_q];
`endif

    assign cur_nibble = active_q.num[{digit_q, 2'b00} +: 4];
    assign cur_dp     = active_q.point[digit_q];

    hex2seg u_hex2seg (
        .nibble_i (cur_nibble),
        .dp_i     (cur_dp),
        .seg_n_o  (glyph_n)
    );

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (!cur_dark) begin
            an_d  = ~(8'h01 << digit_q);
            seg_d = glyph_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= 16'd0;
            digit_q   <= '0;
            pending_q <= 1'b0;
            active_q  <= reset_set();
            shadow_q  <= '0;
            an_q      <= 8'hFF;
            seg_q     <= 8'hFF;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign pending = pending_q;
    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl against a frame-level reference model.
// Blink scenario compiled in when SEG_BLINK_EN is defined.
module tb_seven_seg_scan_ctrl;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int F  = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] disp_num = '0;
    logic [7:0]  point = '0;
    logic [7:0]  blank = '0;
    logic [7:0]  mask_in = '0;
    logic        pending;
    logic        frame_tick;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: k counts clock edges since the last reset.
    int          k = 0;
    logic [31:0] m_num, s_num;
    logic [7:0]  m_pt, s_pt, m_bl, s_bl, m_mk, s_mk;
    logic        m_pend;
    logic [7:0]  e_an, e_seg;

    seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .disp_num   (disp_num),
        .point      (point),
        .blank      (blank),
`ifdef SEG_BLINK_EN
        .blink_mask (mask_in),
`endif
        .pending    (pending),
        .frame_tick (frame_tick),
        .AN         (AN),
        .SEGMENT    (SEGMENT)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segs_on(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @k=%0d: got %0h, expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_num  = 32'hAA5555AA;
        m_pt   = '0; m_bl = '0; m_mk = '0;
        s_num  = '0; s_pt = '0; s_bl = '0; s_mk = '0;
        m_pend = 1'b0;
        e_an   = 8'hFF;
        e_seg  = 8'hFF;
    endtask

    task automatic step();
        bit ft;
        bit phase_off;
        int dig;
        ft = (k % F) == F - 1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            dig = (k / SD) % 8;
`ifdef SEG_BLINK_EN
            phase_off = (((k / F) / BF) % 2) == 1;
`else
            phase_off = 1'b0;
`endif
            if (m_bl[dig] || (phase_off && m_mk[dig])) begin
                e_an  = 8'hFF;
                e_seg = 8'hFF;
            end else begin
                e_an  = 8'hFF ^ (8'h01 << dig);
                e_seg = {~m_pt[dig], ~segs_on(m_num[dig*4 +: 4])};
            end
            if (load) begin
                if (ft) begin
                    m_num = disp_num; m_pt = point; m_bl = blank; m_mk = mask_in;
                    m_pend = 1'b0;
                end else begin
                    s_num = disp_num; s_pt = point; s_bl = blank; s_mk = mask_in;
                    m_pend = 1'b1;
                end
            end else if (ft && m_pend) begin
                m_num = s_num; m_pt = s_pt; m_bl = s_bl; m_mk = s_mk;
                m_pend = 1'b0;
            end
            k++;
        end
        #1;
        check_eq("AN", AN, e_an);
        check_eq("SEGMENT", SEGMENT, e_seg);
        check_eq("pending", pending, m_pend);
        check_eq("frame_tick", frame_tick, ((k % F) == F - 1));
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic do_load(input logic [31:0] n, input logic [7:0] p, input logic [7:0] b,
                           input logic [7:0] m);
        load = 1'b1; disp_num = n; point = p; blank = b; mask_in = m;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state and the plain scan of the reset value
        rst = 1'b1;
        step();
        step();
        check_eq("rst_AN", AN, 8'hFF);
        check_eq("rst_SEG", SEGMENT, 8'hFF);
        rst = 1'b0;
        step();
        check_eq("first_AN", AN, 8'hFE);
        check_eq("first_SEG", SEGMENT, 8'h88);
        run_to(29);
        check_eq("dig7_AN", AN, 8'h7F);
        check_eq("dig7_SEG", SEGMENT, 8'h88);
        run_to(2 * F + 4);

        // Load mid-frame waits for the frame boundary
        do_reset();
        run_to(5);
        do_load(32'h01234567, 8'h00, 8'h00, 8'h00);
        run_to(31);
        check_eq("pend_before_commit", pending, 1'b1);
        run_to(33);
        check_eq("commit_d0_AN", AN, 8'hFE);
        check_eq("commit_d0_SEG", SEGMENT, 8'hF8);
        run_to(61);
        check_eq("commit_d7_SEG", SEGMENT, 8'hC0);

        // Last load in a frame wins
        run_to(66);
        do_load(32'h11111111, 8'h00, 8'h00, 8'h00);
        run_to(70);
        do_load(32'h22222222, 8'h00, 8'h00, 8'h00);
        run_to(97);
        check_eq("last_wins_SEG", SEGMENT, 8'hA4);

        // Load coinciding with frame_tick commits directly
        run_to(127);
        check_eq("ft_at_load", frame_tick, 1'b1);
        do_load(32'hFFFFFFFF, 8'h01, 8'h80, 8'h00);
        check_eq("direct_pend", pending, 1'b0);
        run_to(129);
        check_eq("direct_d0_SEG", SEGMENT, 8'h0E);
        run_to(157);
        check_eq("direct_d7_AN", AN, 8'hFF);
        check_eq("direct_d7_SEG", SEGMENT, 8'hFF);

        // Reset with a pending value discards it
        run_to(160);
        do_load(32'h12345678, 8'h00, 8'h00, 8'h00);
        run_to(170);
        check_eq("pend_pre_rst", pending, 1'b1);
        do_reset();
        check_eq("pend_post_rst", pending, 1'b0);
        step();
        check_eq("rst_return_SEG", SEGMENT, 8'h88);
        run_to(2 * F + 3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 11) == 0) begin
`ifdef SEG_BLINK_EN
                do_load($urandom, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom : 0),
                        8'($urandom));
`else
                do_load($urandom, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom : 0),
                        8'h00);
`endif
            end else begin
                step();
            end
        end

`ifdef SEG_BLINK_EN
        // Blink with mask 0F: frames 2-3 dark on digits 0-3
        do_reset();
        do_load(32'hAA5555AA, 8'h00, 8'h00, 8'h0F);
        run_to(33);
        check_eq("blink_f1_AN", AN, 8'hFE);
        run_to(65);
        check_eq("blink_f2_AN", AN, 8'hFF);
        run_to(81);
        check_eq("blink_f2_d4_AN", AN, 8'hEF);
        run_to(129);
        check_eq("blink_f4_AN", AN, 8'hFE);
        check_eq("blink_f4_SEG", SEGMENT, 8'h88);
        run_to(6 * F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
